// File: rtl/jk_pkg.sv
// Shared definitions for the JK-cell register/counter.
// Mode encodings select the source of each cell's J/K inputs.
// Imported by jk_reg_counter and its testbench.
package jk_pkg;

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        M_JK   = 2'b00,
        M_UP   = 2'b01,
        M_DOWN = 2'b10,
        M_LOAD = 2'b11
    } mode_t;

endpackage

// File: rtl/jkff_cell.sv
// Single-bit JK flip-flop with synchronous active-high reset and clock enable.
// Ports: clk, rst, en, j, k -> q, qbar. Parameter RST_VAL is the reset value.
// Latency one cycle; en=0 holds state. qbar is derived from q so it never diverges.
module jkff_cell #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case ({j, k})
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else if (en) begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;

endmodule

// File: rtl/jk_reg_counter.sv
// WIDTH-bit register built from JK cells: per-bit JK, up-count, down-count, parallel load.
// Ports: clk, rst (sync, active-high), en, mode, j, k, d -> q, qbar, tc. Latency one cycle.
// Optional macro JK_SAT_EN: UP/DOWN saturate at their terminal value instead of wrapping.
module jk_reg_counter
    import jk_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc
);

    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic             at_max;
    logic             at_min;

    assign at_max = &q;
    assign at_min = ~|q;

    // Ripple toggle-enable chains: a bit flips once every lower bit is at
    // the carry (all ones) or borrow (all zeros) value.
    always_comb begin
        t_up    = '0;
        t_dn    = '0;
        t_up[0] = 1'b1;
        t_dn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t_up[i] = t_up[i-1] & q[i-1];
            t_dn[i] = t_dn[i-1] & ~q[i-1];
        end
`ifdef JK_SAT_EN
        // Zero toggles pin the register at its terminal value.
        if (at_max) t_up = '0;
        if (at_min) t_dn = '0;
`endif
    end

    always_comb begin
        cell_j = j;
        cell_k = k;
        case (mode)
            MODE_UP: begin
                cell_j = t_up;
                cell_k = t_up;
            end
            MODE_DOWN: begin
                cell_j = t_dn;
                cell_k = t_dn;
            end
            MODE_LOAD: begin
                // j=d, k=~d is a set or clear per bit, i.e. a plain load.
                cell_j = d;
                cell_k = ~d;
            end
            default: begin
                cell_j = j;
                cell_k = k;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jkff_cell #(
            .RST_VAL (RESET_VAL[i])
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .j    (cell_j[i]),
            .k    (cell_k[i]),
            .q    (q[i]),
            .qbar (qbar[i])
        );
    end

    // Terminal count ignores en so it can gate a cascaded stage.
    assign tc = ((mode == MODE_UP) && at_max) || ((mode == MODE_DOWN) && at_min);

endmodule

// File: tb/tb_jk_reg_counter.sv
module tb_jk_reg_counter;
    import jk_pkg::*;

    localparam int         W    = 4;
    localparam logic [3:0] RV1  = 4'b1010;

    logic         clk = 1'b0;
    logic         rst, en;
    logic [1:0]   mode;
    logic [W-1:0] j, k, d;
    logic [W-1:0] q0, qb0, q1, qb1;
    logic         tc0, tc1;

    always #5 clk = ~clk;

    jk_reg_counter #(.WIDTH(W)) dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .d(d),
        .q(q0), .qbar(qb0), .tc(tc0)
    );

    jk_reg_counter #(.WIDTH(W), .RESET_VAL(RV1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .d(d),
        .q(q1), .qbar(qb1), .tc(tc1)
    );

    typedef struct packed {
        logic [W-1:0] q0;
        logic         tc0;
        logic [W-1:0] q1;
        logic         tc1;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [W-1:0] m0, m1;
    logic         drv_done = 1'b0;

    // Reference model: arithmetic next state, independent of the cell structure.
    function automatic logic [W-1:0] model_next(
        input logic [W-1:0] cur, input logic [W-1:0] rv, input logic r, input logic e,
        input logic [1:0] md, input logic [W-1:0] jj, input logic [W-1:0] kk,
        input logic [W-1:0] dd);
        logic [W-1:0] n;
        n = cur;
        if (r) n = rv;
        else if (e) begin
            case (md)
                MODE_JK: for (int b = 0; b < W; b++)
                    case ({jj[b], kk[b]})
                        2'b01:   n[b] = 1'b0;
                        2'b10:   n[b] = 1'b1;
                        2'b11:   n[b] = ~cur[b];
                        default: n[b] = cur[b];
                    endcase
`ifdef JK_SAT_EN
                MODE_UP:   n = (cur == 4'hF) ? cur : cur + 4'd1;
                MODE_DOWN: n = (cur == 4'h0) ? cur : cur - 4'd1;
`else
                MODE_UP:   n = cur + 4'd1;
                MODE_DOWN: n = cur - 4'd1;
`endif
                default:   n = dd;
            endcase
        end
        return n;
    endfunction

    function automatic logic model_tc(input logic [W-1:0] cur, input logic [1:0] md);
        return ((md == MODE_UP) && (cur == 4'hF)) || ((md == MODE_DOWN) && (cur == 4'h0));
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    endtask

    // Monitor: the register presents a new value after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("q0",    q0,          e.q0);
                check("qbar0", qb0,         ~e.q0);
                check("tc0",   {3'b0, tc0}, {3'b0, e.tc0});
                check("q1",    q1,          e.q1);
                check("qbar1", qb1,         ~e.q1);
                check("tc1",   {3'b0, tc1}, {3'b0, e.tc1});
            end
        end
    end

    // Directed step with hand-computed results for both instances.
    task automatic step(input logic r, input logic e, input logic [1:0] md,
                        input logic [W-1:0] jj, input logic [W-1:0] kk, input logic [W-1:0] dd,
                        input logic [W-1:0] e0, input logic t0,
                        input logic [W-1:0] e1, input logic t1);
        @(negedge clk);
        rst = r; en = e; mode = md; j = jj; k = kk; d = dd;
        exp_q.push_back('{q0: e0, tc0: t0, q1: e1, tc1: t1});
        m0 = e0;
        m1 = e1;
    endtask

    task automatic rand_step();
        logic         r, e;
        logic [1:0]   md;
        logic [W-1:0] jj, kk, dd, n0, n1;
        r  = ($urandom_range(0, 19) == 0);
        e  = ($urandom_range(0, 3) != 0);
        md = 2'($urandom_range(0, 3));
        jj = 4'($urandom);
        kk = 4'($urandom);
        dd = 4'($urandom);
        n0 = model_next(m0, 4'b0000, r, e, md, jj, kk, dd);
        n1 = model_next(m1, RV1,     r, e, md, jj, kk, dd);
        @(negedge clk);
        rst = r; en = e; mode = md; j = jj; k = kk; d = dd;
        exp_q.push_back('{q0: n0, tc0: model_tc(n0, md), q1: n1, tc1: model_tc(n1, md)});
        m0 = n0;
        m1 = n1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = MODE_JK; j = '0; k = '0; d = '0;
        m0 = '0; m1 = RV1;

        // Reset
        step(1, 0, MODE_JK,   4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 4'b1010, 0);
        // JK: bit3 set, bit2 toggle, bit1 clear, bit0 hold; then toggle all
        step(0, 1, MODE_JK,   4'b1100, 4'b0110, 4'b0000, 4'b1100, 0, 4'b1100, 0);
        step(0, 1, MODE_JK,   4'b1111, 4'b1111, 4'b0000, 4'b0011, 0, 4'b0011, 0);
        // UP across the top
        step(0, 1, MODE_LOAD, 4'b0000, 4'b0000, 4'b1110, 4'b1110, 0, 4'b1110, 0);
        step(0, 1, MODE_UP,   4'b0000, 4'b0000, 4'b0000, 4'b1111, 1, 4'b1111, 1);
`ifdef JK_SAT_EN
        step(0, 1, MODE_UP,   4'b0000, 4'b0000, 4'b0000, 4'b1111, 1, 4'b1111, 1);
        step(0, 1, MODE_UP,   4'b0000, 4'b0000, 4'b0000, 4'b1111, 1, 4'b1111, 1);
`else
        step(0, 1, MODE_UP,   4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0);
        step(0, 1, MODE_UP,   4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 4'b0001, 0);
`endif
        // DOWN across the bottom
        step(0, 1, MODE_LOAD, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 0, 4'b0001, 0);
        step(0, 1, MODE_DOWN, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 1);
`ifdef JK_SAT_EN
        step(0, 1, MODE_DOWN, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 1);
`else
        step(0, 1, MODE_DOWN, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 4'b1111, 0);
`endif
        // Enable low holds for 5 cycles
        step(0, 1, MODE_LOAD, 4'b0000, 4'b0000, 4'b0101, 4'b0101, 0, 4'b0101, 0);
        for (int c = 0; c < 5; c++)
            step(0, 0, MODE_UP, 4'b1111, 4'b1111, 4'b1111, 4'b0101, 0, 4'b0101, 0);
        // tc follows q even with en low
        step(0, 1, MODE_LOAD, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 0, 4'b1111, 0);
        step(0, 0, MODE_UP,   4'b0000, 4'b0000, 4'b0000, 4'b1111, 1, 4'b1111, 1);
        // Reset wins over enable and load
        step(1, 1, MODE_LOAD, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 0, 4'b1010, 0);

        for (int c = 0; c < 1000; c++) rand_step();

        @(negedge clk);
        en = 1'b0;
        drv_done = 1'b1;
    end

    initial begin
        wait (drv_done);
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete, expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

endmodule
